// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types and reader FSM states for the sample buffer reader.
package audio_pkg;
  localparam int SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [SAMPLE_W-1:0] mag_t;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} rdr_state_t;
endpackage

// File: rtl/sample_buf_reader_if.sv
// sample_buf_reader_if: buffer request, RAM read port, sample stream and status of the reader.
interface sample_buf_reader_if #(
  parameter int DEPTH = 16,
  parameter int OVR_W = 8
);
  import audio_pkg::*;
  logic buf_ready_i;
  logic buf_sel_i;
  logic rd_en_o;
  logic [$clog2(2*DEPTH)-1:0] rd_addr_o;
  sample_t rd_data_i;
  sample_t sample_o;
  logic sample_valid_o;
  logic sample_last_o;
  logic sample_ready_i;
  logic busy_o;
  logic [OVR_W-1:0] overrun_o;
  mag_t peak_o;
  logic peak_valid_o;
  modport slave (
    input buf_ready_i, buf_sel_i, rd_data_i, sample_ready_i,
    output rd_en_o, rd_addr_o, sample_o, sample_valid_o, sample_last_o, busy_o, overrun_o, peak_o, peak_valid_o
  );
  modport master (
    output buf_ready_i, buf_sel_i, rd_data_i, sample_ready_i,
    input rd_en_o, rd_addr_o, sample_o, sample_valid_o, sample_last_o, busy_o, overrun_o, peak_o, peak_valid_o
  );
endinterface

// File: rtl/sample_peak_tracker.sv
// sample_peak_tracker: running max of |sample| per buffer, published on a strobe.
module sample_peak_tracker
  import audio_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    clr_i,
  input  logic    upd_i,
  input  logic    pub_i,
  input  sample_t sample_i,
  output mag_t    peak_o,
  output logic    peak_valid_o
);
  mag_t mag, run_q;
  // Two's-complement negate keeps |-2^23| as 24'h800000 in the unsigned result
  assign mag = sample_i[SAMPLE_W-1] ? mag_t'(-sample_i) : mag_t'(sample_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= '0;
      peak_o <= '0;
      peak_valid_o <= 1'b0;
    end else begin
      if (upd_i) run_q <= (clr_i || mag > run_q) ? mag : run_q;
      if (pub_i) peak_o <= run_q;
      peak_valid_o <= pub_i;
    end
  end
endmodule

// File: rtl/sample_buf_reader.sv
// sample_buf_reader: streams ping-pong buffer halves from a sync RAM to a ready/valid consumer.
// Define SAMPLE_BUF_READER_PEAK_EN to add per-buffer peak magnitude tracking.
module sample_buf_reader
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVR_W = 8
) (
  input logic clk_i,
  input logic rst_ni,
  sample_buf_reader_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  rdr_state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic half_q, pend_v_q, pend_sel_q;
  sample_t sample_q;
  logic valid_q, last_q;
  logic [OVR_W-1:0] ovr_q;
  logic xfer, fin;
  always_comb begin
    xfer = state_q == PRESENT && valid_q && bus.sample_ready_i;
    fin = xfer && &idx_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.buf_ready_i ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = PRESENT;
      PRESENT: state_d = !xfer ? PRESENT : (fin && !pend_v_q && !bus.buf_ready_i) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      half_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_sel_q <= 1'b0;
      sample_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      ovr_q <= '0;
    end else begin
      if (state_q == IDLE && bus.buf_ready_i) begin
        half_q <= bus.buf_sel_i;
        idx_q <= '0;
      end
      if (state_q == WAIT) begin
        sample_q <= bus.rd_data_i;
        valid_q <= 1'b1;
        last_q <= &idx_q;
      end
      if (xfer) begin
        valid_q <= 1'b0;
        last_q <= 1'b0;
        idx_q <= idx_q + 1'b1;
      end
      // A request coinciding with the final transfer refills the slot being consumed
      if (fin) begin
        half_q <= pend_v_q ? pend_sel_q : bus.buf_sel_i;
        pend_v_q <= pend_v_q && bus.buf_ready_i;
        pend_sel_q <= bus.buf_sel_i;
      end else if (state_q != IDLE && bus.buf_ready_i) begin
        if (!pend_v_q) begin
          pend_v_q <= 1'b1;
          pend_sel_q <= bus.buf_sel_i;
        end else if (~&ovr_q) begin
          ovr_q <= ovr_q + 1'b1;
        end
      end
    end
  end
  assign bus.rd_en_o = state_q == FETCH;
  assign bus.rd_addr_o = {half_q, idx_q};
  assign bus.sample_o = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.sample_last_o = last_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.overrun_o = ovr_q;
`ifdef SAMPLE_BUF_READER_PEAK_EN
  sample_peak_tracker u_peak (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (idx_q == '0),
    .upd_i        (state_q == WAIT),
    .pub_i        (fin),
    .sample_i     (bus.rd_data_i),
    .peak_o       (bus.peak_o),
    .peak_valid_o (bus.peak_valid_o)
  );
`else
  assign bus.peak_o = '0;
  assign bus.peak_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_sample_buf_reader.sv
// tb_sample_buf_reader: randomized and directed checks of sample_buf_reader against a queue-based model.
module tb_sample_buf_reader;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic signed [23:0] mem [2*D];
  int q[$];
  int midx = 0;
  int drops = 0;
  int xfers = 0;
  int lasts = 0;
  bit pv_due = 1'b0;
  int exp_peak = 0;
  sample_buf_reader_if #(.DEPTH(D), .OVR_W(8)) bus();
  sample_buf_reader #(.DEPTH(D), .OVR_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int mag_of(int v);
    return v < 0 ? -v : v;
  endfunction
  // Model: queue of accepted halves (head = being read, at most one waiting) plus read index
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      midx = 0;
      drops = 0;
      pv_due = 1'b0;
      exp_peak = 0;
    end else begin
      chk("busy", 32'(bus.busy_o), 32'(q.size() != 0));
      chk("overrun", 32'(bus.overrun_o), drops > 255 ? 255 : drops);
      chk("peak_valid", 32'(bus.peak_valid_o), 32'(pv_due));
      chk("peak", 32'(bus.peak_o), exp_peak);
      pv_due = 1'b0;
      chk("rd_en_idle", 32'(bus.rd_en_o && q.size() == 0), 0);
      chk("valid_rden", 32'(bus.sample_valid_o && bus.rd_en_o), 0);
      if (bus.rd_en_o && q.size() != 0) chk("rd_addr", 32'(bus.rd_addr_o), q[0] * D + midx);
      if (bus.sample_valid_o && q.size() != 0) begin
        chk("sample", 32'(bus.sample_o), 32'(mem[q[0] * D + midx]));
        chk("last", 32'(bus.sample_last_o), 32'(midx == D - 1));
      end
      if (bus.sample_valid_o && bus.sample_ready_i && q.size() != 0) begin
        xfers++;
        if (bus.sample_last_o) lasts++;
        if (midx == D - 1) begin
`ifdef SAMPLE_BUF_READER_PEAK_EN
          exp_peak = 0;
          for (int i = 0; i < D; i++) if (mag_of(int'(mem[q[0] * D + i])) > exp_peak) exp_peak = mag_of(int'(mem[q[0] * D + i]));
          pv_due = 1'b1;
`endif
          void'(q.pop_front());
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (bus.buf_ready_i) begin
        if (q.size() < 2) q.push_back(int'(bus.buf_sel_i));
        else drops++;
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(bit s);
    bus.buf_ready_i = 1'b1;
    bus.buf_sel_i = s;
    tick();
    bus.buf_ready_i = 1'b0;
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    while (bus.busy_o && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < lim), 1);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(bus.rd_en_o), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr_o), 0);
    chk("rst_sample", 32'(bus.sample_o), 0);
    chk("rst_valid", 32'({bus.sample_valid_o, bus.sample_last_o}), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_overrun", 32'(bus.overrun_o), 0);
    chk("rst_peak", 32'({bus.peak_valid_o, bus.peak_o}), 0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    logic signed [23:0] held;
    logic [4:0] held_a;
    int n;
    bus.buf_ready_i = 1'b0;
    bus.buf_sel_i = 1'b0;
    bus.sample_ready_i = 1'b1;
    bus.rd_data_i = '0;
    for (int i = 0; i < 2 * D; i++) mem[i] = 24'($urandom);
    apply_reset();
    // Full buffer on half 1 with an always-ready consumer, plus first-sample latency
    n = xfers;
    lasts = 0;
    pulse(1'b1);
    chk("lat_rd_en", 32'(bus.rd_en_o), 1);
    chk("lat_addr", 32'(bus.rd_addr_o), 16);
    tick();
    chk("lat_wait", 32'({bus.rd_en_o, bus.sample_valid_o}), 0);
    tick();
    chk("lat_valid", 32'(bus.sample_valid_o), 1);
    wait_idle(100);
    chk("xfer_count", 32'(xfers - n), 16);
    chk("last_count", 32'(lasts), 1);
    // Consumer stall: everything must hold for 10 cycles
    bus.sample_ready_i = 1'b0;
    pulse(1'b0);
    n = 0;
    while (!bus.sample_valid_o && n < 10) begin tick(); n++; end
    held = bus.sample_o;
    held_a = bus.rd_addr_o;
    repeat (10) begin
      tick();
      chk("stall_sample", 32'(bus.sample_o), 32'(held));
      chk("stall_valid", 32'(bus.sample_valid_o), 1);
      chk("stall_rd_en", 32'(bus.rd_en_o), 0);
      chk("stall_addr", 32'(bus.rd_addr_o), 32'(held_a));
    end
    bus.sample_ready_i = 1'b1;
    wait_idle(100);
    // Three requests during one buffer: one pending, one dropped
    bus.sample_ready_i = 1'b0;
    pulse(1'b0);
    tick(2);
    pulse(1'b1);
    tick(2);
    pulse(1'b0);
    tick();
    chk("ovr_three", 32'(bus.overrun_o), 1);
    bus.sample_ready_i = 1'b1;
    wait_idle(200);
    // Random requests and consumer backpressure
    for (int i = 0; i < 1500; i++) begin
      bus.buf_ready_i = $urandom_range(0, 19) == 0;
      bus.buf_sel_i = 1'($urandom);
      bus.sample_ready_i = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.buf_ready_i = 1'b0;
    bus.sample_ready_i = 1'b1;
    wait_idle(300);
    // Overrun saturation
    apply_reset();
    bus.sample_ready_i = 1'b0;
    pulse(1'b0);
    repeat (300) pulse(1'b1);
    tick();
    chk("ovr_sat", 32'(bus.overrun_o), 255);
    bus.sample_ready_i = 1'b1;
    wait_idle(300);
    // Reset in the middle of a buffer
    pulse(1'b0);
    n = 0;
    while (!(bus.sample_valid_o && bus.rd_addr_o[3:0] == 4'd7) && n < 100) begin tick(); n++; end
    chk("mid_reach", 32'(n < 100), 1);
    apply_reset();
    repeat (20) begin
      tick();
      chk("post_rst_quiet", 32'({bus.rd_en_o, bus.sample_valid_o}), 0);
    end
    pulse(1'b1);
    chk("post_rst_addr", 32'(bus.rd_addr_o), 16);
    wait_idle(100);
    // Peak magnitude with the most negative sample present
    apply_reset();
    for (int i = 0; i < D; i++) mem[i] = 24'($urandom_range(0, 90));
    mem[0] = 24'sd5;
    mem[1] = -24'sd8388608;
    mem[2] = 24'sd100;
    pulse(1'b0);
    wait_idle(100);
`ifdef SAMPLE_BUF_READER_PEAK_EN
    chk("peak_pulse", 32'(bus.peak_valid_o), 1);
    tick();
    chk("peak_value", 32'(bus.peak_o), 32'h800000);
`else
    chk("peak_pulse", 32'(bus.peak_valid_o), 0);
    tick();
    chk("peak_value", 32'(bus.peak_o), 0);
`endif
    chk("peak_pulse_end", 32'(bus.peak_valid_o), 0);
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sample_buf_reader.md
SAMPLE_BUF_READER -- requirements
Module: sample_buf_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: samples per buffer half; a power of two, at least 2.
REQ-002 SHALL have parameter OVR_W, default 8: width of the overrun counter.
REQ-003 SHALL have input clk_i, 1 bit: single system clock (27 MHz); one clock only.
REQ-004 SHALL have input rst_ni, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have inputs buf_ready_i (1 bit, one-cycle pulse: a buffer half is full) and buf_sel_i (1 bit: which half, sampled with the pulse).
REQ-006 SHALL have outputs rd_en_o (1 bit) and rd_addr_o ($clog2(2*DEPTH) bits): synchronous RAM read port; MSB is the half, LSBs are the index.
REQ-007 SHALL have input rd_data_i, signed 24 bits: RAM read data, valid exactly 1 cycle after rd_en_o.
REQ-008 SHALL have outputs sample_o (signed 24 bits), sample_valid_o (1 bit) and sample_last_o (1 bit); sample_last_o marks index DEPTH-1.
REQ-009 SHALL have input sample_ready_i, 1 bit: consumer handshake.
REQ-010 SHALL have outputs busy_o (1 bit) and overrun_o (OVR_W bits).
REQ-011 SHALL have outputs peak_o (24 bits, unsigned) and peak_valid_o (1 bit), both under REQ-030.

Function
REQ-012 SHALL use FSM states IDLE, FETCH, WAIT and PRESENT.
REQ-013 IDLE: on buf_ready_i, latch buf_sel_i as the current half, index := 0, go to FETCH.
REQ-014 FETCH: drive rd_en_o=1 for exactly one cycle with rd_addr_o={half,index}, then go to WAIT.
REQ-015 WAIT: capture rd_data_i into the sample_o register, set sample_valid_o=1, go to PRESENT.
REQ-016 PRESENT: hold sample_o, sample_valid_o and sample_last_o stable until sample_valid_o && sample_ready_i.
REQ-017 Transfer in PRESENT with index != DEPTH-1: index++, go to FETCH the next cycle, with sample_valid_o=0 in that cycle.
REQ-018 Transfer in PRESENT with index == DEPTH-1: go to FETCH on the pending half if one is pending, otherwise go to IDLE.
REQ-019 Latency: buf_ready_i at cycle 0 gives rd_en_o at cycle 1 and sample_valid_o at cycle 3; minimum period is 3 cycles per sample.
REQ-020 buf_ready_i while not in IDLE, with the pending slot empty: store buf_sel_i in the 1-deep pending slot.
REQ-021 buf_ready_i while not in IDLE, with the pending slot full: drop the request and increment overrun_o, saturating at 2^OVR_W-1.
REQ-022 buf_ready_i in the same cycle as the final transfer: the new request fills the pending slot, which is consumed that same cycle; no overrun.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 rd_en_o SHALL never be asserted outside FETCH.
REQ-025 Index wraps only by buffer completion; rd_addr_o SHALL never exceed 2*DEPTH-1.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE, and all of the following to 0: rd_en_o, rd_addr_o, sample_o, sample_valid_o, sample_last_o, busy_o, overrun_o, peak_o, peak_valid_o.
REQ-027 Reset SHALL clear the pending slot and the index.
REQ-028 Reset mid-buffer SHALL abandon the buffer; no sample is presented after deassertion until a new buf_ready_i.
REQ-029 Registers SHALL use asynchronous assert with no reset synchroniser inside the block.

Configuration
REQ-030 Macro SAMPLE_BUF_READER_PEAK_EN defined: track the maximum |sample| over each buffer, reset at index 0.
REQ-031 |-8388608| SHALL equal 24'h800000, unsigned and unsaturated.
REQ-032 With the macro, peak_o updates and peak_valid_o pulses for 1 cycle on the cycle after the last-sample transfer; peak_o holds until the next buffer's update.
REQ-033 Macro undefined: peak_o=0 and peak_valid_o=0 constantly, and no peak logic is synthesised.

Structure
REQ-034 Package audio_pkg SHALL hold: SAMPLE_W=24, typedef sample_t (signed [SAMPLE_W-1:0]), typedef mag_t (unsigned [SAMPLE_W-1:0]), and enum rdr_state_t {IDLE, FETCH, WAIT, PRESENT}.
REQ-035 Sub-module sample_peak_tracker (abs plus running max, clear and update strobes) SHALL be instantiated only under SAMPLE_BUF_READER_PEAK_EN.

Verification
REQ-036 DEPTH=16, buf_ready_i with sel=1, sample_ready_i=1: rd_addr_o = 16..31 in order; 16 transfers; sample_last_o only on the 16th; busy_o falls after it.
REQ-037 sample_ready_i low for 10 cycles in PRESENT: sample_o and sample_valid_o stable; rd_en_o=0; no address advance.
REQ-038 Three buf_ready_i pulses (sel 0,1,0) during one buffer: second is pending and served next with addresses 16..31; third is dropped; overrun_o=1.
REQ-039 300 dropped requests with OVR_W=8: overrun_o saturates at 255.
REQ-040 rst_ni low at sample index 7, then high: all outputs 0 immediately; no rd_en_o until the next buf_ready_i, which starts at index 0.
REQ-041 With PEAK_EN, RAM contains {5, -8388608, 100, ...}: peak_o=24'h800000 and peak_valid_o pulses 1 cycle after the last transfer; without PEAK_EN both stay 0.
